spi_master_engine: RTL and testbench

Active SPI initiator for the MITM bridge. On a `start` pulse it drives SS, SCLK and MOSI to shift out one `DATA_SIZE`-bit word MSB-first, and samples MISO into a parallel word. It is the transmitting, clock-owning counterpart of the passive sniff/rewrite path. Its pins feed the fake side of the output multiplexer, so the MITM controller can inject complete transactions instead of only rewriting bits.

---
 rtl/spi_master_engine_pkg.sv | 17 +
 rtl/spi_master_engine_sclk_half_period_timer.sv | 26 ++
 rtl/spi_master_engine.sv | 141 ++++++++++++++
 tb/tb_spi_master_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_engine_pkg.sv
// Shared definitions for the SPI initiator: FSM state encodings and the
// mode-0 SCLK level convention also used by the sniff buffers.
package spi_master_engine_pkg;

    typedef enum logic [2:0] {
        SPI_M_IDLE  = 3'd0,
        SPI_M_SETUP = 3'd1,
        SPI_M_HIGH  = 3'd2,
        SPI_M_LOW   = 3'd3,
        SPI_M_HOLD  = 3'd4
    } spi_m_state_e;

    // Mode 0: SCLK idles low, MISO/MOSI sampled on the rising edge.
    localparam logic SCLK_IDLE   = 1'b0;
    localparam logic SCLK_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_master_engine_sclk_half_period_timer.sv
// Half-period timer: after clear, tick rises once every CLK_DIV cycles.
module sclk_half_period_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// Mode-0 SPI initiator: on start, shifts one DATA_SIZE-bit word out MSB-first on
// MOSI while capturing MISO, so the bridge can inject complete transactions.
module spi_master_engine
    import spi_master_engine_pkg::*;
#(
    parameter int   DATA_SIZE = 8,
    parameter int   CLK_DIV   = 2,
    parameter logic SS_ACTIVE = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 miso_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 busy,
    output logic                 data_ready,
    output logic                 sclk_out,
    output logic                 ss_out,
    output logic                 mosi_out
);
    localparam int BW = $clog2(DATA_SIZE + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_SIZE);

    spi_m_state_e         state, state_nx;
    logic [DATA_SIZE-1:0] tx, tx_nx, rx, rx_nx, dout_nx, tx_shl, rx_shl;
    logic [BW-1:0]        bits, bits_nx;
    logic                 sclk_nx, ss_nx, mosi_nx, busy_nx, ready_nx;
    logic                 clear, tick;

    sclk_half_period_timer #(.CLK_DIV(CLK_DIV)) timer (
        .sys_clk (sys_clk),
        .rst     (rst),
        .clear   (clear),
        .tick    (tick)
    );

    assign tx_shl = tx << 1;
    assign rx_shl = DATA_SIZE'({rx, miso_in});

    always_comb begin
        state_nx = state;
        tx_nx    = tx;
        rx_nx    = rx;
        bits_nx  = bits;
        sclk_nx  = sclk_out;
        ss_nx    = ss_out;
        mosi_nx  = mosi_out;
        busy_nx  = busy;
        ready_nx = 1'b0;
        dout_nx  = data_out;
        clear    = 1'b0;
        case (state)
            SPI_M_IDLE: begin
                clear = 1'b1;
                if (start) begin
                    tx_nx    = data_in;
                    rx_nx    = '0;
                    bits_nx  = '0;
                    state_nx = SPI_M_SETUP;
                end
            end
            SPI_M_SETUP: begin
                // First SETUP edge drives the pins; the CLK_DIV wait starts after it.
                if (!busy) begin
                    clear   = 1'b1;
                    ss_nx   = SS_ACTIVE;
                    busy_nx = 1'b1;
                    mosi_nx = tx[DATA_SIZE-1];
                end else if (tick) begin
                    clear    = 1'b1;
                    sclk_nx  = SCLK_ACTIVE;
                    rx_nx    = rx_shl;
                    bits_nx  = bits + 1'b1;
                    state_nx = SPI_M_HIGH;
                end
            end
            SPI_M_HIGH: begin
                if (tick) begin
                    clear   = 1'b1;
                    sclk_nx = SCLK_IDLE;
                    if (bits < LAST_BIT) begin
                        tx_nx    = tx_shl;
                        mosi_nx  = tx_shl[DATA_SIZE-1];
                        state_nx = SPI_M_LOW;
                    end else begin
                        state_nx = SPI_M_HOLD;
                    end
                end
            end
            SPI_M_LOW: begin
                if (tick) begin
                    clear    = 1'b1;
                    sclk_nx  = SCLK_ACTIVE;
                    rx_nx    = rx_shl;
                    bits_nx  = bits + 1'b1;
                    state_nx = SPI_M_HIGH;
                end
            end
            SPI_M_HOLD: begin
                if (tick) begin
                    clear    = 1'b1;
                    ss_nx    = ~SS_ACTIVE;
                    mosi_nx  = 1'b0;
                    busy_nx  = 1'b0;
                    dout_nx  = rx;
                    ready_nx = 1'b1;
                    state_nx = SPI_M_IDLE;
                end
            end
            default: state_nx = SPI_M_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= SPI_M_IDLE;
            tx         <= '0;
            rx         <= '0;
            bits       <= '0;
            sclk_out   <= SCLK_IDLE;
            ss_out     <= ~SS_ACTIVE;
            mosi_out   <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_nx;
            tx         <= tx_nx;
            rx         <= rx_nx;
            bits       <= bits_nx;
            sclk_out   <= sclk_nx;
            ss_out     <= ss_nx;
            mosi_out   <= mosi_nx;
            busy       <= busy_nx;
            data_ready <= ready_nx;
            data_out   <= dout_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: two configurations driven together, each checked
// every cycle against a timing-formula model, plus directed literal expectations.
module tb_spi_master_engine;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din [2];
    logic [31:0] resp_fix [2];
    bit          use_fix = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int   D  = (g == 0) ? 8 : 4;
        localparam int   C  = (g == 0) ? 2 : 5;
        localparam logic SA = (g == 0) ? 1'b1 : 1'b0;
        localparam int   T  = 1 + (2 * D + 1) * C;

        logic [D-1:0] dout;
        logic         sclk, ss, mosi, busy, rdy;
        logic         miso = 1'b0;

        spi_master_engine #(.DATA_SIZE(D), .CLK_DIV(C), .SS_ACTIVE(SA)) dut (
            .sys_clk    (sys_clk),
            .rst        (rst),
            .start      (start),
            .data_in    (din[g][D-1:0]),
            .miso_in    (miso),
            .data_out   (dout),
            .busy       (busy),
            .data_ready (rdy),
            .sclk_out   (sclk),
            .ss_out     (ss),
            .mosi_out   (mosi)
        );

        // Model state: one transaction accepted at edge a, sending W, responder word R.
        int          a = 0, idle_from = 0, acc_id = 0, seen_id = 0, rb = 0;
        bit          act = 1'b0, prev_sclk = 1'b0;
        logic [31:0] W = 0, R = 0, dexp = 0, cap = 0;
        int          rdy_cnt = 0, rdy_last = 0, rdy_prev = 0, rdy_rel = 0;

        always @(posedge sys_clk) begin
            if (rst) begin
                act = 1'b0;
                dexp = 0;
                idle_from = 0;
            end else begin
                if (act && cyc == a + T) dexp = R;
                if (start && cyc >= idle_from) begin
                    a = cyc;
                    act = 1'b1;
                    idle_from = cyc + T + 1;
                    W = din[g];
                    R = (use_fix ? resp_fix[g] : $urandom) & ((32'd1 << D) - 1);
                    acc_id++;
                end
            end
        end

        always @(negedge sys_clk) begin
            int n, m, j;
            logic [4:0] e_ctl;
            logic [31:0] e_dout;
            n = cyc - 1 - a;
            if (rst) begin
                e_ctl = {1'b0, 1'b0, ~SA, 1'b0, 1'b0};
                e_dout = 0;
            end else if (act && n >= 1 && n <= T - 1) begin
                m = n - 1;
                j = m / (2 * C);
                if (j > D - 1) j = D - 1;
                e_ctl = {((m / C) % 2 == 1) && (m / C < 2 * D), W[D-1-j], SA, 1'b1, 1'b0};
                e_dout = dexp;
            end else begin
                e_ctl = {1'b0, 1'b0, ~SA, 1'b0, act && n == T};
                e_dout = dexp;
            end
            chk($sformatf("g%0d {sclk,mosi,ss,busy,rdy}", g), 32'({sclk, mosi, ss, busy, rdy}), 32'(e_ctl));
            chk($sformatf("g%0d data_out", g), 32'(dout), e_dout);

            // Responder and observation bookkeeping.
            if (acc_id != seen_id) begin
                seen_id = acc_id;
                rb = 0;
                cap = 0;
            end
            if (!prev_sclk && sclk) cap = {cap[30:0], mosi};
            if (prev_sclk && !sclk) rb++;
            prev_sclk = sclk;
            miso = (rb < D) ? R[D-1-rb] : 1'b0;
            if (rdy && !rst) begin
                rdy_cnt++;
                rdy_prev = rdy_last;
                rdy_last = cyc - 1;
                rdy_rel = cyc - 1 - a;
            end
        end
    end

    initial begin
        int snap0, snap1;
        din[0] = 0;
        din[1] = 0;
        resp_fix[0] = 32'h3C;
        resp_fix[1] = 32'hF;
        repeat (3) @(posedge sys_clk);
        #3 rst = 1'b0;
        repeat (3) step();

        // Basic transfer with an ignored start at cycle 10.
        snap0 = u[0].rdy_cnt;
        snap1 = u[1].rdy_cnt;
        start = 1'b1; din[0] = 32'hA5; din[1] = 32'h9;
        step();
        start = 1'b0; din[0] = 32'h00; din[1] = 32'h0;
        repeat (9) step();
        start = 1'b1; din[0] = 32'hFF; din[1] = 32'hF;
        step();
        start = 1'b0;
        repeat (60) step();
        chk("g0 mosi at rising edges", 32'(u[0].cap[7:0]), 32'hA5);
        chk("g0 data_ready cycle", 32'(u[0].rdy_rel), 32'd35);
        chk("g0 data_out", 32'(u[0].dout), 32'h3C);
        chk("g0 single ready pulse", 32'(u[0].rdy_cnt - snap0), 32'd1);
        chk("g1 mosi at rising edges", 32'(u[1].cap[3:0]), 32'h9);
        chk("g1 data_ready cycle", 32'(u[1].rdy_rel), 32'd46);
        chk("g1 data_out", 32'(u[1].dout), 32'hF);
        chk("g1 single ready pulse", 32'(u[1].rdy_cnt - snap1), 32'd1);

        // Back-to-back with start held high.
        resp_fix[0] = 32'h5A;
        resp_fix[1] = 32'h6;
        start = 1'b1; din[0] = 32'h96; din[1] = 32'h3;
        repeat (100) step();
        start = 1'b0;
        chk("g0 ready spacing", 32'(u[0].rdy_last - u[0].rdy_prev), 32'd36);
        chk("g1 ready spacing", 32'(u[1].rdy_last - u[1].rdy_prev), 32'd47);
        repeat (60) step();
        chk("g0 b2b data_out", 32'(u[0].dout), 32'h5A);
        chk("g1 b2b data_out", 32'(u[1].dout), 32'h6);

        // Reset at cycle 12 of a transfer.
        start = 1'b1; din[0] = 32'h3E; din[1] = 32'hC;
        step();
        start = 1'b0;
        repeat (11) step();
        @(posedge sys_clk);
        #3 rst = 1'b1;
        #1;
        chk("g0 ss after reset", 32'(u[0].ss), 32'd0);
        chk("g1 ss after reset", 32'(u[1].ss), 32'd1);
        chk("g0 busy/sclk/mosi after reset", 32'({u[0].busy, u[0].sclk, u[0].mosi}), 32'd0);
        chk("g0 data_out after reset", 32'(u[0].dout), 32'd0);
        chk("g1 data_out after reset", 32'(u[1].dout), 32'd0);
        snap0 = u[0].rdy_cnt;
        snap1 = u[1].rdy_cnt;
        @(posedge sys_clk);
        #3 rst = 1'b0;
        repeat (60) step();
        chk("g0 no ready after abort", 32'(u[0].rdy_cnt - snap0), 32'd0);
        chk("g1 no ready after abort", 32'(u[1].rdy_cnt - snap1), 32'd0);
        resp_fix[0] = 32'hC3;
        resp_fix[1] = 32'hA;
        start = 1'b1; din[0] = 32'h71; din[1] = 32'h5;
        step();
        start = 1'b0;
        repeat (60) step();
        chk("g0 clean transfer data_out", 32'(u[0].dout), 32'hC3);
        chk("g0 clean transfer mosi", 32'(u[0].cap[7:0]), 32'h71);
        chk("g1 clean transfer data_out", 32'(u[1].dout), 32'hA);

        // Randomized traffic with occasional asynchronous resets.
        use_fix = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            start = ($urandom_range(0, 3) == 0);
            din[0] = $urandom;
            din[1] = $urandom;
            rst = ($urandom_range(0, 399) == 0);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
